// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types for the FFT bit-reverse reorder buffer: complex sample
// types and the bit-reversal helper used to scatter incoming samples.
package fft_bitrev_reorder_pkg;

   // Real/imag width of the FFT input sample; products are twice as wide.
   localparam int SAMPLE_WIDTH  = 16;
   localparam int PRODUCT_WIDTH = 2 * SAMPLE_WIDTH;

   typedef struct packed {
      logic signed [SAMPLE_WIDTH-1:0] r;
      logic signed [SAMPLE_WIDTH-1:0] i;
   } complex_t;

   typedef struct packed {
      logic signed [PRODUCT_WIDTH-1:0] r;
      logic signed [PRODUCT_WIDTH-1:0] i;
   } complex_product_t;

   // Reverse the low 'width' bits of 'value'; bits above 'width' come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] result;
      result = '0;
      for (int b = 0; b < width; b++) begin
         result[width-1-b] = value[b];
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle between an FFT core, the reorder buffer and its
// consumer. The slave modport is the reorder buffer's view.
interface fft_bitrev_reorder_if;
   import fft_bitrev_reorder_pkg::*;

   logic             in_valid;
   complex_product_t in_data;
   logic             in_ready;
   logic             out_valid;
   complex_product_t out_data;
   logic             out_ready;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fft_reorder_bank.sv
// One N-entry sample memory with a single write port and a registered
// read port, shaped so synthesis can map it onto block RAM.
module fft_reorder_bank #(
   parameter int N     = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_we,
   input  logic [$clog2(N)-1:0]     i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(N)-1:0]     i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [N];
   logic [WIDTH-1:0] r_rdata;

   // Write port: contents are never cleared, stale frames are simply ignored.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; the output register clears so the stream idles at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output reorder buffer: accepts frames in bit-reversed order and
// replays them in natural order through a ping-pong pair of banks.
// Optional feature: define FFT_REORDER_FRAME_CNT_EN to add the 16-bit
// frame_count output counting delivered frames.
module fft_bitrev_reorder
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,  // must agree with SAMPLE_WIDTH in the package
   parameter int N          = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   fft_bitrev_reorder_if.slave   bus
`ifdef FFT_REORDER_FRAME_CNT_EN
   ,
   output logic [15:0]           frame_count
`endif
);
   localparam int AW     = $clog2(N);
   localparam int WORD_W = 4 * DATA_WIDTH;

   logic [AW-1:0]     r_wr_cnt;
   logic              r_wr_bank;
   logic [1:0]        r_full;
   logic [AW-1:0]     r_rd_addr;
   logic              r_rd_bank;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_out_sel;

   logic              w_accept;
   logic              w_wr_done;
   logic              w_load;
   logic              w_rd_done;
   logic [AW-1:0]     w_wr_addr;
   logic [WORD_W-1:0] w_wdata;
   logic [WORD_W-1:0] w_rdata [2];

   assign bus.in_ready = ~r_full[r_wr_bank];
   assign w_accept     = bus.in_valid & ~r_full[r_wr_bank];
   assign w_wr_done    = w_accept & (r_wr_cnt == AW'(N - 1));
   assign w_wr_addr    = AW'(bitrev(32'(r_wr_cnt), AW));
   assign w_wdata      = bus.in_data;

   // Output register advances when empty or when the consumer takes the current sample.
   assign w_load    = r_full[r_rd_bank] & (~r_out_valid | bus.out_ready);
   assign w_rd_done = w_load & (r_rd_addr == AW'(N - 1));

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         fft_reorder_bank #(.N(N), .WIDTH(WORD_W)) u_bank (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_accept & (r_wr_bank == 1'(gi))),
            .i_waddr (w_wr_addr),
            .i_wdata (w_wdata),
            .i_re    (w_load & (r_rd_bank == 1'(gi))),
            .i_raddr (r_rd_addr),
            .o_rdata (w_rdata[gi])
         );
      end
   endgenerate

   // Write side: count samples of the frame and swap banks after the last one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_accept) begin
         if (w_wr_done) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
      end
   end

   // Full flags: fill and drain always target different banks, so both may update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= '0;
      end else begin
         if (w_wr_done) begin
            r_full[r_wr_bank] <= 1'b1;
         end
         if (w_rd_done) begin
            r_full[r_rd_bank] <= 1'b0;
         end
      end
   end

   // Read side: walk the full bank in natural order and track output validity.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_addr   <= '0;
         r_rd_bank   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_sel   <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_last  <= (r_rd_addr == AW'(N - 1));
         r_out_sel   <= r_rd_bank;
         if (w_rd_done) begin
            r_rd_addr <= '0;
            r_rd_bank <= ~r_rd_bank;
         end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
         end
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.out_data  = complex_product_t'(w_rdata[r_out_sel]);

`ifdef FFT_REORDER_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Count frames whose final sample has been handed downstream; wraps at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
      end else if (r_out_valid & r_out_last & bus.out_ready) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_count = r_frame_cnt;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for the bit-reverse reorder buffer (N=8). Inputs are
// driven 1 time unit after the rising edge; the monitor samples on the
// falling edge and pops expected samples on every handshake.
module tb_fft_bitrev_reorder;
   import fft_bitrev_reorder_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fft_bitrev_reorder_if ifc ();

`ifdef FFT_REORDER_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   fft_bitrev_reorder #(.DATA_WIDTH(16), .N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
`ifdef FFT_REORDER_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   typedef struct packed {
      complex_product_t d;
      logic             last;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   int   first_rise_cyc = -1;
   int   last_accept_cyc = 0;
   int   stalls = 0;
   bit   chk_contig = 1'b0;
   int   contig_seen = 0;
   int   gaps = 0;
   bit   toggle_en = 1'b0;

   logic             prev_valid = 1'b0;
   logic             prev_ready = 1'b0;
   logic             prev_last = 1'b0;
   complex_product_t prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: handshake scoreboard, hold-while-stalled and contiguity tracking.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 64'(ifc.out_valid), 64'd1);
            check("hold_data", ifc.out_data, prev_data);
            check("hold_last", 64'(ifc.out_last), 64'(prev_last));
         end
         if (ifc.out_valid && first_rise_cyc < 0) first_rise_cyc = cyc;
         if (ifc.out_valid && ifc.out_ready) begin
            $display("out cyc=%0d r=%0d i=%0d last=%0b", cyc, ifc.out_data.r, ifc.out_data.i, ifc.out_last);
            if (sb_q.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("out_data", ifc.out_data, e.d);
               check("out_last", 64'(ifc.out_last), 64'(e.last));
            end
            if (chk_contig) contig_seen++;
         end else if (chk_contig && contig_seen > 0 && contig_seen < 24) begin
            gaps++;
         end
         prev_valid = ifc.out_valid;
         prev_ready = ifc.out_ready;
         prev_data  = ifc.out_data;
         prev_last  = ifc.out_last;
      end
   end

   // Consumer that alternates ready every cycle when enabled.
   always @(posedge clk) begin
      #1;
      if (toggle_en) ifc.out_ready = ~ifc.out_ready;
   end

   // Present one sample; returns one time unit after the edge that accepted it.
   task automatic send_sample(input int r, input int i);
      int waits;
      waits = 0;
      ifc.in_valid  = 1'b1;
      ifc.in_data.r = 32'(r);
      ifc.in_data.i = 32'(i);
      while (!ifc.in_ready && waits < 200) begin
         @(posedge clk);
         #1;
         waits++;
         stalls++;
      end
      if (waits >= 200) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
      last_accept_cyc = cyc;
      ifc.in_valid = 1'b0;
   endtask

   // Queue the natural-order expectation, then drive the bit-reversed frame.
   task automatic send_frame(input int base, input int ibase, input bit imag_on);
      for (int n = 0; n < 8; n++) begin
         exp_t e;
         e.d.r  = 32'(base + n);
         e.d.i  = imag_on ? 32'(ibase + n) : 32'd0;
         e.last = (n == 7);
         sb_q.push_back(e);
      end
      for (int k = 0; k < 8; k++) begin
         send_sample(base + br_tab[k], imag_on ? (ibase + br_tab[k]) : 0);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      ifc.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
      check({tag, "_out_last"}, 64'(ifc.out_last), 64'd0);
      check({tag, "_out_data"}, ifc.out_data, 64'd0);
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state("reset");

      // Single frame, imaginary parts zero, latency and out_last position.
      send_frame(0, 0, 1'b0);
      drain();
      check("first_valid_latency", 64'(first_rise_cyc), 64'(last_accept_cyc + 1));

      // Three back-to-back frames with no bubbles.
      pulse_reset();
      stalls = 0;
      contig_seen = 0;
      gaps = 0;
      chk_contig = 1'b1;
      send_frame(16, 1000, 1'b1);
      send_frame(24, 2000, 1'b1);
      send_frame(32, 3000, 1'b1);
      drain();
      chk_contig = 1'b0;
      check("contig_outputs", 64'(contig_seen), 64'd24);
      check("contig_gaps", 64'(gaps), 64'd0);
      check("contig_in_stalls", 64'(stalls), 64'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
      check("frame_count", 64'(frame_count), 64'd3);
`endif

      // Consumer stalled for 20 cycles while two frames arrive.
      ifc.out_ready = 1'b0;
      send_frame(0, 500, 1'b1);
      send_frame(8, 600, 1'b1);
      check("stall_in_ready_low", 64'(ifc.in_ready), 64'd0);
      check("stall_out_valid", 64'(ifc.out_valid), 64'd1);
      check("stall_out_data_r", 64'(ifc.out_data.r), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("stall_out_data_r_end", 64'(ifc.out_data.r), 64'd0);
      ifc.out_ready = 1'b1;
      drain();

      // Consumer ready toggling every cycle.
      toggle_en = 1'b1;
      send_frame(300, 4000, 1'b1);
      send_frame(308, 4100, 1'b1);
      drain();
      toggle_en = 1'b0;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;

      // Reset in the middle of a frame, then one clean frame.
      for (int k = 0; k < 5; k++) send_sample(100 + br_tab[k], 0);
      pulse_reset();
      check_reset_state("midreset");
      send_frame(200, 7000, 1'b1);
      drain();
      repeat (20) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(sb_q.size()), 64'd0);
      check("final_out_valid", 64'(ifc.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
